plic_gateway: RTL

Per-source interrupt gateway in front of the PLIC core. Synchronizes raw peripheral interrupt lines, applies level- or edge-triggered qualification per source, and holds each source in IDLE / PENDING / IN_SERVICE so a source raises at most one outstanding request until the PLIC reports completion. Its `irq_req` vector feeds the PLIC pending-bit inputs. It consumes the claim/complete strobes the PLIC decodes from AHB reads and writes of the claim/complete register.

---
 rtl/plic_pkg.sv | 27 ++
 rtl/plic_gateway_cell.sv | 124 ++++++++++++
 rtl/plic_gateway.sv | 52 +++++
 3 files changed

// File: rtl/plic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : plic_pkg
//  Description : Shared types and constants for the PLIC interrupt gateway:
//                per-source state encoding, edge-counter width and the
//                claim/complete ID width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package plic_pkg;

    // Per-source gateway state; 2'b11 is unused and recovers to idle.
    typedef enum logic [1:0] {
        GW_IDLE       = 2'd0,
        GW_PENDING    = 2'd1,
        GW_IN_SERVICE = 2'd2
    } gw_state_t;

    localparam int                    GW_CNT_W   = 3;
    localparam logic [GW_CNT_W-1:0]   GW_CNT_MAX = '1;

    // ID 0 is reserved for "no interrupt", so n sources need ids 0..n.
    function automatic int gw_id_width(input int n_src);
        return $clog2(n_src + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/plic_gateway_cell.sv
`default_nettype none
// ============================================================================
//  Module      : plic_gateway_cell
//  Description : One interrupt source: synchronizer chain, rising-edge
//                detect, IDLE/PENDING/IN_SERVICE state machine and, when
//                PLIC_GW_EDGE_COUNT_EN is defined, a saturating counter of
//                edges that arrive while a request is already outstanding.
//  Revision    : 1.0 - initial release
// ============================================================================
module plic_gateway_cell
    import plic_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic irq_src,
    input  logic edge_sel,
    input  logic claim_hit,
    input  logic complete_hit,
    output logic irq_req,
    output logic in_service
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_d;
    logic                   w_s;
    logic                   w_rise;
    logic                   w_trigger;
    logic                   w_rearm;
    logic                   w_cnt_nz;
    gw_state_t              r_state;
    gw_state_t              w_state_nxt;

    assign w_s       = r_sync[SYNC_STAGES-1];
    assign w_rise    = w_s & ~r_s_d;
    assign w_trigger = edge_sel ? w_rise : w_s;

    // Synchronize the raw line and keep one delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_s_d  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], irq_src};
            r_s_d  <= w_s;
        end
    end

`ifdef PLIC_GW_EDGE_COUNT_EN
    logic [GW_CNT_W-1:0] r_cnt;
    logic                w_cnt_inc;
    logic                w_cnt_dec;

    // A rise at the completing edge re-arms directly and is not counted.
    assign w_cnt_inc = edge_sel & w_rise &
                       ((r_state == GW_PENDING) |
                        ((r_state == GW_IN_SERVICE) & ~complete_hit));
    assign w_cnt_dec = (r_state == GW_IN_SERVICE) & complete_hit & w_cnt_nz;
    assign w_cnt_nz  = (r_cnt != '0);

    // Count edges swallowed while busy; cleared whenever the source is level mode
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!edge_sel) begin
            r_cnt <= '0;
        end else if (w_cnt_inc) begin
            if (r_cnt != GW_CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else if (w_cnt_dec) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end
`else
    assign w_cnt_nz = 1'b0;
`endif

    // A completion re-arms if the source is still asking for service
    assign w_rearm = (~edge_sel & w_s) | (edge_sel & w_rise) | w_cnt_nz;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= GW_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; strobes that do not fit the current state are ignored
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            GW_IDLE: begin
                if (w_trigger) begin
                    w_state_nxt = GW_PENDING;
                end
            end
            GW_PENDING: begin
                if (claim_hit) begin
                    w_state_nxt = GW_IN_SERVICE;
                end
            end
            GW_IN_SERVICE: begin
                if (complete_hit) begin
                    w_state_nxt = w_rearm ? GW_PENDING : GW_IDLE;
                end
            end
            default: begin
                w_state_nxt = GW_IDLE;
            end
        endcase
    end

    // Outputs decode the state flops directly
    always_comb begin
        irq_req    = (r_state == GW_PENDING);
        in_service = (r_state == GW_IN_SERVICE);
    end

endmodule
`default_nettype wire

// File: rtl/plic_gateway.sv
`default_nettype none
// ============================================================================
//  Module      : plic_gateway
//  Description : PLIC interrupt gateway. Decodes claim/complete IDs into
//                per-source hits and instantiates one gateway cell per
//                source. Define PLIC_GW_EDGE_COUNT_EN to enable per-source
//                counting of edges that arrive while a request is outstanding.
//  Revision    : 1.0 - initial release
// ============================================================================
module plic_gateway
    import plic_pkg::*;
#(
    parameter  int N_interrupts = 32,
    parameter  int SYNC_STAGES  = 2,
    localparam int ID_W         = gw_id_width(N_interrupts)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_interrupts-1:0] irq_src,
    input  logic [N_interrupts-1:0] edge_sel,
    input  logic                    claim_valid,
    input  logic [ID_W-1:0]         claim_id,
    input  logic                    complete_valid,
    input  logic [ID_W-1:0]         complete_id,
    output logic [N_interrupts-1:0] irq_req,
    output logic [N_interrupts-1:0] in_service
);

    logic [N_interrupts-1:0] w_claim_hit;
    logic [N_interrupts-1:0] w_complete_hit;

    // Source i answers to ID i+1; ID 0 and out-of-range IDs match nothing.
    for (genvar gi = 0; gi < N_interrupts; gi++) begin : g_cell
        assign w_claim_hit[gi]    = claim_valid    & (claim_id    == ID_W'(gi + 1));
        assign w_complete_hit[gi] = complete_valid & (complete_id == ID_W'(gi + 1));

        plic_gateway_cell #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_cell (
            .clk          (clk),
            .rst          (rst),
            .irq_src      (irq_src[gi]),
            .edge_sel     (edge_sel[gi]),
            .claim_hit    (w_claim_hit[gi]),
            .complete_hit (w_complete_hit[gi]),
            .irq_req      (irq_req[gi]),
            .in_service   (in_service[gi])
        );
    end

endmodule
`default_nettype wire
